bird_motion_fsm: RTL
====================

Name: bird_motion_fsm

Overview:
- Parametrised successor to the single-bird physics state machine. Generates the bird's X/Y screen position from Start and Flap_Button.
- Uses a signed velocity, a programmable tick divider and terminal velocity, and detects floor, ceiling and external (pipe) collisions.
- Sits between the input debouncers and the VGA renderer/collision logic. Its one-hot state outputs drive the LEDs and the score/game-over logic.

Parameters:
- Y_W, 10, width of the XBird/YBird coordinates.
- VEL_W, 6, width of the signed velocity (two's complement; positive = downward).
- TICK_DIV, 2000000, Clk cycles per physics tick (must be >= 2).
- X_INIT, 500, fixed bird X coordinate.
- Y_INIT, 100, Y on entry to IDLE.
- GRAV_STEP, 1, velocity increment per tick.
- MAX_FALL, 20, terminal downward velocity (must be < 2^(VEL_W-1)).
- FLAP_VEL, 15, magnitude of the upward velocity loaded on a flap.
- Y_FLOOR, 460, lowest legal Y; Y >= Y_FLOOR is a loss.
- Y_CEIL, 0, highest legal Y; a computed Y < Y_CEIL is a ceiling hit.

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, asynchronous, active-high reset.
- Start, in, 1, level; begins a game from IDLE and returns to IDLE from LOST.
- Flap_Button, in, 1, debounced level.
- Lost_Ext, in, 1, pipe collision from the renderer; level, sampled each cycle.
- XBird, out, Y_W, bird X.
- YBird, out, Y_W, bird Y.
- Vel, out, VEL_W, current signed velocity.
- Tick, out, 1, one-cycle pulse on each physics update.
- q_I, q_Fall, q_Rise, q_Hold, q_Lost, out, 1 each, one-hot state indicators.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, YBird=Y_INIT, XBird=X_INIT, Vel=0, tick counter=0, Tick=0.
  - Asserting Reset mid-game returns to these values immediately, with no partial update.
- States are one-hot: IDLE, FALL, RISE, HOLD, LOST. The q_* outputs mirror them directly and exactly one is high.
- Tick counter:
  - Runs only in FALL/RISE/HOLD and counts 0..TICK_DIV-1.
  - Tick is a registered pulse in the cycle after the counter reaches TICK_DIV-1, after which the counter wraps to 0.
  - The counter clears on every state entry.
- Physics update on Tick:
  - Y_next = YBird + sign-extended Vel, computed at Y_W+2 bits signed.
  - Vel_next = min(Vel + GRAV_STEP, MAX_FALL) in all active states.
- IDLE:
  - Holds Y_INIT, Vel=0.
  - Start=1 -> FALL on the next edge.
- FALL:
  - Flap_Button=1 -> RISE; Vel <= -FLAP_VEL and the counter clears in that same cycle.
  - A flap overrides any coincident Tick; that Tick's update is discarded.
- RISE:
  - Ticks apply physics.
  - When Vel_next >= 0: Flap_Button=1 -> HOLD, otherwise -> FALL.
- HOLD:
  - Same physics as FALL; flaps are ignored.
  - Flap_Button=0 -> FALL.
  - Holding the button never produces a second flap.
- Loss detection (active states only, priority highest first):
  1. Lost_Ext=1 -> LOST.
  2. On Tick, Y_next >= Y_FLOOR -> LOST with YBird=Y_FLOOR.
  3. On Tick, Y_next < Y_CEIL -> LOST with YBird=Y_CEIL.
  4. Otherwise, a flap.
- In all loss cases Vel <= 0.
- LOST:
  - Freezes YBird; Tick=0.
  - Start=1 AND Flap_Button=0 -> IDLE. Start held together with Flap is ignored, so a held button cannot skip the game-over screen.
- XBird is constant X_INIT in every state.

Optional Feature:
- Macro CEILING_BOUNCE_EN.
- Defined: a ceiling hit is not a loss. YBird <= Y_CEIL, Vel <= 0, state -> FALL (from RISE or HOLD); floor and Lost_Ext are unchanged.
- Undefined: a ceiling hit -> LOST as specified above.

Decomposition:
- Package bird_pkg holds:
  - one-hot state localparams (S_IDLE=5'b00001, S_FALL=5'b00010, S_RISE=5'b00100, S_HOLD=5'b01000, S_LOST=5'b10000);
  - default physics constants;
  - the screen bounds shared with the renderer.
- One sub-module, phys_tick_gen: parametrised TICK_DIV counter with clear and enable, producing Tick. The state machine and position datapath stay in bird_motion_fsm.

Test Plan:
- Bench uses TICK_DIV=4. Reset, then Start=1: next edge q_Fall=1. After 3 ticks YBird=100+0+1+2=103 and Vel=3.
- In FALL, pulse Flap_Button for 1 cycle: q_Rise, Vel=-15. The next tick gives YBird decreasing by 15, and RISE -> FALL once Vel reaches 0.
- Flap and hold the button for 100 ticks: RISE -> HOLD, no second flap, Vel saturates at 20. Release -> FALL.
- Fall from Y=450 with Vel=12: the tick yields LOST, YBird=460, Vel=0. Start with Flap=1 stays LOST; Start with Flap=0 -> IDLE, YBird=100.
- Repeated flaps from Y=20:
  - Macro off -> LOST with YBird=0.
  - Macro on -> FALL with YBird=0, Vel=0.
- Lost_Ext=1 coincident with a Tick and a flap in FALL: LOST wins and Y is not updated. Reset asserted mid-RISE: immediate IDLE, YBird=100.

Source files
------------

// File: rtl/bird_pkg.sv
// rtl/bird_pkg.sv - shared state encoding, physics defaults and screen bounds for the bird motion logic
//
// Purpose : one-hot state codes for bird_motion_fsm, default physics constants,
//           and the vertical screen limits shared with the renderer.
// Ports   : none (package).

package bird_pkg;

    // One-hot codes; bit positions line up with the q_I/q_Fall/q_Rise/q_Hold/q_Lost outputs.
    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_FALL = 5'b00010,
        S_RISE = 5'b00100,
        S_HOLD = 5'b01000,
        S_LOST = 5'b10000
    } state_t;

    // Default physics constants.
    localparam int DEF_Y_W       = 10;
    localparam int DEF_VEL_W     = 6;
    localparam int DEF_TICK_DIV  = 2000000;
    localparam int DEF_X_INIT    = 500;
    localparam int DEF_Y_INIT    = 100;
    localparam int DEF_GRAV_STEP = 1;
    localparam int DEF_MAX_FALL  = 20;
    localparam int DEF_FLAP_VEL  = 15;

    // Vertical play-field limits, also used by the renderer.
    localparam int SCREEN_Y_FLOOR = 460;
    localparam int SCREEN_Y_CEIL  = 0;

    // The in-flight states, where the physics tick runs and losses are checked.
    function automatic logic is_active(input state_t s);
        return (s == S_FALL) || (s == S_RISE) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/phys_tick_gen.sv
// rtl/phys_tick_gen.sv - programmable divider producing the one-cycle physics tick
//
// Purpose : counts 0..TICK_DIV-1 while enabled and emits a registered one-cycle
//           tick in the cycle after the counter reaches TICK_DIV-1.
// Ports   : Clk    - system clock
//           Reset  - asynchronous active-high reset
//           clear  - restart the count from 0 (state entry, flap)
//           enable - count only while high; low holds the counter at 0
//           tick   - one-cycle physics update pulse

module phys_tick_gen
    import bird_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (clear || !enable) begin
            // A clear also kills a pending tick so a fresh state never sees a stale update.
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/bird_motion_fsm.sv
// rtl/bird_motion_fsm.sv - bird physics state machine producing the bird X/Y position
//
// Purpose : drives the bird's screen position from Start and Flap_Button with a
//           signed velocity, gravity, terminal velocity and floor/ceiling/pipe
//           collision detection.
// Macro   : CEILING_BOUNCE_EN - when defined a ceiling hit drops the bird back
//           into FALL instead of ending the game.
// Ports   : Clk          - system clock
//           Reset        - asynchronous active-high reset
//           Start        - level; starts a game from IDLE, leaves LOST
//           Flap_Button  - debounced level
//           Lost_Ext     - pipe collision from the renderer, level
//           XBird/YBird  - bird position (Y_W bits)
//           Vel          - signed velocity, positive is downward (VEL_W bits)
//           Tick         - one-cycle pulse per physics update
//           q_I, q_Fall, q_Rise, q_Hold, q_Lost - one-hot state indicators

module bird_motion_fsm
    import bird_pkg::*;
#(
    parameter int Y_W       = DEF_Y_W,
    parameter int VEL_W     = DEF_VEL_W,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int X_INIT    = DEF_X_INIT,
    parameter int Y_INIT    = DEF_Y_INIT,
    parameter int GRAV_STEP = DEF_GRAV_STEP,
    parameter int MAX_FALL  = DEF_MAX_FALL,
    parameter int FLAP_VEL  = DEF_FLAP_VEL,
    parameter int Y_FLOOR   = SCREEN_Y_FLOOR,
    parameter int Y_CEIL    = SCREEN_Y_CEIL
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Flap_Button,
    input  logic             Lost_Ext,
    output logic [Y_W-1:0]   XBird,
    output logic [Y_W-1:0]   YBird,
    output logic [VEL_W-1:0] Vel,
    output logic             Tick,
    output logic             q_I,
    output logic             q_Fall,
    output logic             q_Rise,
    output logic             q_Hold,
    output logic             q_Lost
);

    state_t           state_q, state_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic             flap_load;
    logic             ctr_clear;
    logic             ctr_enable;

    // Physics datapath. Two extra bits on Y keep the sum free of wrap so both
    // the floor and the negative (ceiling) side compare correctly.
    logic signed [Y_W+1:0] y_sum;
    logic signed [VEL_W:0] vel_inc;
    logic [VEL_W-1:0]      vel_next;
    logic                  floor_hit;
    logic                  ceil_hit;

    assign y_sum    = $signed({2'b00, y_q})
                    + $signed({{(Y_W+2-VEL_W){vel_q[VEL_W-1]}}, vel_q});
    assign vel_inc  = $signed({vel_q[VEL_W-1], vel_q}) + $signed((VEL_W+1)'(GRAV_STEP));
    assign vel_next = (vel_inc > $signed((VEL_W+1)'(MAX_FALL))) ? VEL_W'(MAX_FALL)
                                                                : vel_inc[VEL_W-1:0];
    assign floor_hit = (y_sum >= $signed((Y_W+2)'(Y_FLOOR)));
    assign ceil_hit  = (y_sum <  $signed((Y_W+2)'(Y_CEIL)));

    // The divider restarts on every state entry and on a flap so the first
    // update after either always comes a full period later.
    assign ctr_enable = is_active(state_q);
    assign ctr_clear  = (state_d != state_q) || flap_load;

    phys_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (ctr_clear),
        .enable (ctr_enable),
        .tick   (Tick)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            y_q     <= Y_W'(Y_INIT);
            vel_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        vel_d     = vel_q;
        flap_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                y_d   = Y_W'(Y_INIT);
                vel_d = '0;
                if (Start) begin
                    state_d = S_FALL;
                end
            end

            S_FALL, S_RISE, S_HOLD: begin
                // Loss sources outrank a flap; a flap outranks a plain tick update.
                if (Lost_Ext) begin
                    state_d = S_LOST;
                    vel_d   = '0;
                end else if (Tick && floor_hit) begin
                    state_d = S_LOST;
                    y_d     = Y_W'(Y_FLOOR);
                    vel_d   = '0;
                end else if (Tick && ceil_hit) begin
`ifdef CEILING_BOUNCE_EN
                    state_d = S_FALL;
`else
                    state_d = S_LOST;
`endif
                    y_d     = Y_W'(Y_CEIL);
                    vel_d   = '0;
                end else if ((state_q == S_FALL) && Flap_Button) begin
                    // The coincident tick, if any, is dropped.
                    state_d   = S_RISE;
                    vel_d     = VEL_W'(-FLAP_VEL);
                    flap_load = 1'b1;
                end else begin
                    if (Tick) begin
                        y_d   = y_sum[Y_W-1:0];
                        vel_d = vel_next;
                    end
                    // Apex: the climb ends once the new velocity stops pointing up.
                    if ((state_q == S_RISE) && Tick && !vel_next[VEL_W-1]) begin
                        state_d = Flap_Button ? S_HOLD : S_FALL;
                    end
                    // HOLD only leaves on release, so a held button cannot re-flap.
                    if ((state_q == S_HOLD) && !Flap_Button) begin
                        state_d = S_FALL;
                    end
                end
            end

            S_LOST: begin
                // Start with the button held is ignored so the game-over screen stays up.
                if (Start && !Flap_Button) begin
                    state_d = S_IDLE;
                    y_d     = Y_W'(Y_INIT);
                    vel_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                y_d     = Y_W'(Y_INIT);
                vel_d   = '0;
            end
        endcase
    end

    assign {q_Lost, q_Hold, q_Rise, q_Fall, q_I} = state_q;
    assign XBird = Y_W'(X_INIT);
    assign YBird = y_q;
    assign Vel   = vel_q;

endmodule
